// File: rtl/mif_mem_ctrl_pkg.sv
// Shared types and default geometry for the MIF line-buffer memory controller.
`ifndef MIFAddrBits
`define MIFAddrBits 16
`endif
`ifndef MIFTagBits
`define MIFTagBits 4
`endif
`ifndef MIFDataBits
`define MIFDataBits 32
`endif

package mem_pkg;

  localparam int ADDR_W = `MIFAddrBits;
  localparam int TAG_W  = `MIFTagBits;
  localparam int DATA_W = `MIFDataBits;

  localparam int DEFAULT_LINE_IDX_BITS = 8;
  localparam int DEFAULT_DATA_BEATS    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

endpackage

// File: rtl/mif_mem_ctrl_if.sv
// Command / write-data / read-response bundle between a requester and the controller.
interface mif_mem_ctrl_if;
  import mem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [TAG_W-1:0]  req_tag;
  logic              req_rw;

  logic              data_valid;
  logic              data_ready;
  logic [DATA_W-1:0] data_data;

  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic [TAG_W-1:0]  resp_tag;

  modport slave (
    input  req_valid, req_addr, req_tag, req_rw,
    input  data_valid, data_data,
    output req_ready, data_ready,
    output resp_valid, resp_data, resp_tag
  );

  modport master (
    output req_valid, req_addr, req_tag, req_rw,
    output data_valid, data_data,
    input  req_ready, data_ready,
    input  resp_valid, resp_data, resp_tag
  );

endinterface

// File: rtl/mif_mem_ctrl_array.sv
// Single-port line storage: synchronous write, registered read, no reset on contents.
module mem_array #(
  parameter int AddrBits = 10,
  parameter int DataBits = 32
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AddrBits-1:0] addr,
  input  logic [DataBits-1:0] wdata,
  output logic [DataBits-1:0] rdata
);

  localparam int Depth = 1 << AddrBits;

  logic [DataBits-1:0] mem [Depth];
  logic [DataBits-1:0] rdata_reg;

  // Read-during-write returns the old word; the controller never relies on it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_reg <= mem[addr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/mif_mem_ctrl.sv
// Line-oriented memory controller: one command moves DataBeats beats into or out of a line.
module mif_mem_ctrl
  import mem_pkg::*;
#(
  parameter int LineIdxBits = DEFAULT_LINE_IDX_BITS,
  parameter int DataBeats   = DEFAULT_DATA_BEATS
) (
  input  logic          clk,
  input  logic          rst,
  mif_mem_ctrl_if.slave bus
);

  localparam int BeatBits    = $clog2(DataBeats);
  localparam int ArrAddrBits = LineIdxBits + BeatBits;
  localparam logic [BeatBits-1:0] LastBeat = BeatBits'(DataBeats - 1);

  state_t                 state_reg;
  logic [BeatBits-1:0]    beat_reg;
  logic [LineIdxBits-1:0] line_reg;
  logic [TAG_W-1:0]       tag_reg;
  logic [TAG_W-1:0]       resp_tag_reg;
  logic                   req_ready_reg;
  logic                   data_ready_reg;
  logic                   resp_valid_reg;

  logic                   req_fire;
  logic                   data_fire;
  logic                   last_beat;
  logic [ArrAddrBits-1:0] arr_addr;
  logic [DATA_W-1:0]      arr_rdata;

  assign req_fire  = bus.req_valid & req_ready_reg;
  assign data_fire = bus.data_valid & data_ready_reg;
  assign last_beat = (beat_reg == LastBeat);
  assign arr_addr  = {line_reg, beat_reg};

  // Address bits above the line index are deliberately dropped so lines alias.
  generate
    if (LineIdxBits < ADDR_W) begin : g_alias
      wire unused_addr_hi = ^bus.req_addr[ADDR_W-1:LineIdxBits];
    end
  endgenerate

  // req_ready rises one cycle after returning to IDLE, which yields a
  // two-cycle gap between consecutive read bursts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      beat_reg       <= '0;
      line_reg       <= '0;
      tag_reg        <= '0;
      resp_tag_reg   <= '0;
      req_ready_reg  <= 1'b1;
      data_ready_reg <= 1'b0;
      resp_valid_reg <= 1'b0;
    end else begin
      resp_valid_reg <= (state_reg == READ);
      resp_tag_reg   <= tag_reg;
      case (state_reg)
        IDLE: begin
          data_ready_reg <= 1'b0;
          if (req_fire) begin
            line_reg      <= bus.req_addr[LineIdxBits-1:0];
            tag_reg       <= bus.req_tag;
            beat_reg      <= '0;
            req_ready_reg <= 1'b0;
            if (bus.req_rw) begin
              state_reg      <= WRITE;
              data_ready_reg <= 1'b1;
            end else begin
              state_reg <= READ;
            end
          end else begin
            req_ready_reg <= 1'b1;
          end
        end
        WRITE: begin
          req_ready_reg <= 1'b0;
          if (data_fire) begin
            beat_reg <= beat_reg + 1'b1;
            if (last_beat) begin
              state_reg      <= IDLE;
              data_ready_reg <= 1'b0;
            end
          end
        end
        READ: begin
          req_ready_reg  <= 1'b0;
          data_ready_reg <= 1'b0;
          beat_reg       <= beat_reg + 1'b1;
          if (last_beat) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg      <= IDLE;
          beat_reg       <= '0;
          req_ready_reg  <= 1'b0;
          data_ready_reg <= 1'b0;
        end
      endcase
    end
  end

  mem_array #(
    .AddrBits (ArrAddrBits),
    .DataBits (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (data_fire),
    .addr  (arr_addr),
    .wdata (bus.data_data),
    .rdata (arr_rdata)
  );

  assign bus.req_ready  = req_ready_reg;
  assign bus.data_ready = data_ready_reg;
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_data  = arr_rdata;
  assign bus.resp_tag   = resp_tag_reg;

endmodule
